// File: rtl/i8259_lite.sv
`default_nettype none
// ============================================================================
//  Module      : i8259_lite
//  Description : 8-input fixed-priority interrupt controller with edge-captured
//                requests, mask, in-service tracking, vectored acknowledge, EOI.
//  Revision    : 1.0 - initial release
// ============================================================================
module i8259_lite #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [1:0] a,
    input  logic [7:0] idata,
    output logic [7:0] odata,
    input  logic [7:0] ir,
    input  logic       inta,
    output logic       intr,
    output logic [7:0] ivec
);

    localparam logic [2:0] c_CMD_NS_EOI = 3'b001;
    localparam logic [2:0] c_CMD_SP_EOI = 3'b011;
    localparam logic [3:0] c_NONE       = 4'd8;

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]        warm_q, warm_d;
    logic [7:0]                  edge_q, edge_d;
    logic [7:0]                  irr_q,  irr_d;
    logic [7:0]                  isr_q,  isr_d;
    logic [7:0]                  imr_q,  imr_d;
    logic [4:0]                  base_q, base_d;
    logic                        intr_q, intr_d;
    logic [7:0]                  ivec_q, ivec_d;

    logic [7:0] w_sync;
    logic [7:0] w_rise;
    logic [7:0] w_req;
    logic [3:0] w_p;
    logic [3:0] w_s;
    logic       w_intr_next;
    logic       w_wr;
    logic [7:0] w_ack_mask;
    logic [7:0] w_eoi_mask;

    // Index of lowest set bit, 8 when the vector is empty.
    function automatic logic [3:0] lowest(input logic [7:0] v);
        logic [3:0] idx;
        idx = c_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ir};
        warm_d = {warm_q[SYNC_STAGES-1:0], 1'b1};
        w_sync = sync_q[SYNC_STAGES-1];
        edge_d = w_sync;
        // Suppress edges until the chain holds post-reset samples, so a line
        // already high at reset release is not mistaken for a new request.
        w_rise = w_sync & ~edge_q & {8{warm_q[SYNC_STAGES]}};

        w_req       = irr_q & ~imr_q;
        w_p         = lowest(w_req);
        w_s         = lowest(isr_q);
        w_intr_next = (w_req != 8'h00) && (w_p < w_s);
        w_wr        = cs & wr;

        w_ack_mask = 8'h00;
        if (inta && w_intr_next) begin
            w_ack_mask = 8'h01 << w_p[2:0];
        end

        w_eoi_mask = 8'h00;
        if (w_wr && (a == 2'd0)) begin
            if ((idata[7:5] == c_CMD_NS_EOI) && (w_s != c_NONE)) begin
                w_eoi_mask = 8'h01 << w_s[2:0];
            end else if (idata[7:5] == c_CMD_SP_EOI) begin
                w_eoi_mask = 8'h01 << idata[2:0];
            end
        end

        // New edge wins over the acknowledge clear; EOI acts on pre-edge ISR.
        irr_d  = (irr_q & ~w_ack_mask) | w_rise;
        isr_d  = (isr_q & ~w_eoi_mask) | w_ack_mask;
        imr_d  = (w_wr && (a == 2'd1)) ? idata : imr_q;
        base_d = (w_wr && (a == 2'd3)) ? idata[7:3] : base_q;
        intr_d = w_intr_next;

        ivec_d = ivec_q;
        if (inta) begin
            ivec_d = w_intr_next ? {base_q, w_p[2:0]} : {base_q, 3'b111};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            warm_q <= '0;
            edge_q <= 8'h00;
            irr_q  <= 8'h00;
            isr_q  <= 8'h00;
            imr_q  <= 8'hFF;
            base_q <= 5'd0;
            intr_q <= 1'b0;
            ivec_q <= 8'h00;
        end else begin
            sync_q <= sync_d;
            warm_q <= warm_d;
            edge_q <= edge_d;
            irr_q  <= irr_d;
            isr_q  <= isr_d;
            imr_q  <= imr_d;
            base_q <= base_d;
            intr_q <= intr_d;
            ivec_q <= ivec_d;
        end
    end

    always_comb begin
        odata = 8'h00;
        if (cs && rd) begin
            case (a)
                2'd0:    odata = irr_q;
                2'd1:    odata = imr_q;
                2'd2:    odata = isr_q;
                default: odata = {base_q, 3'b000};
            endcase
        end
    end

    assign intr = intr_q;
    assign ivec = ivec_q;

endmodule
`default_nettype wire

// File: tb/tb_i8259_lite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i8259_lite
//  Description : Self-checking bench for i8259_lite against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i8259_lite;

    localparam int c_SS = 2;

    logic       clk;
    logic       reset;
    logic       cs, rd, wr, inta;
    logic [1:0] a;
    logic [7:0] idata, odata, ir, ivec;
    logic       intr;

    int n_tests = 0;
    int n_fail  = 0;

    i8259_lite #(.SYNC_STAGES(c_SS)) dut (
        .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .a(a),
        .idata(idata), .odata(odata), .ir(ir), .inta(inta),
        .intr(intr), .ivec(ivec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: registers as plain variables, ir history as a queue
    // of per-edge samples (newest first).
    logic [7:0] m_irr, m_isr, m_imr, m_ivec;
    logic [4:0] m_base;
    logic       m_intr;
    logic [7:0] hist[$];

    function automatic int low(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic logic [7:0] model_reg(input logic [1:0] adr);
        case (adr)
            2'd0:    return m_irr;
            2'd1:    return m_imr;
            2'd2:    return m_isr;
            default: return {m_base, 3'b000};
        endcase
    endfunction

    logic [7:0] mv_req, mv_rise, mv_eoi, mv_ack;
    int         mv_p, mv_s;
    bit         mv_nxt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_base = 5'd0;
            m_ivec = 8'h00; m_intr = 1'b0;
            hist.delete();
        end else begin
            mv_req = m_irr & ~m_imr;
            mv_p   = low(mv_req);
            mv_s   = low(m_isr);
            mv_nxt = (mv_req != 0) && (mv_p < mv_s);
            hist.push_front(ir);
            if (hist.size() > c_SS + 2) void'(hist.pop_back());
            mv_rise = 8'h00;
            if (hist.size() == c_SS + 2) mv_rise = hist[c_SS] & ~hist[c_SS+1];
            mv_eoi = 8'h00;
            if (cs && wr && a == 2'd0) begin
                if (idata[7:5] == 3'b001 && mv_s < 8) mv_eoi[mv_s] = 1'b1;
                if (idata[7:5] == 3'b011) mv_eoi[idata[2:0]] = 1'b1;
            end
            mv_ack = 8'h00;
            if (inta) begin
                if (mv_nxt) begin
                    mv_ack[mv_p] = 1'b1;
                    m_ivec = {m_base, 3'(mv_p)};
                end else begin
                    m_ivec = {m_base, 3'b111};
                end
            end
            m_irr = (m_irr & ~mv_ack) | mv_rise;
            m_isr = (m_isr & ~mv_eoi) | mv_ack;
            if (cs && wr && a == 2'd1) m_imr = idata;
            if (cs && wr && a == 2'd3) m_base = idata[7:3];
            m_intr = mv_nxt;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset: registered outputs against the model.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("intr_cyc", {7'd0, intr}, {7'd0, m_intr});
            chk("ivec_cyc", ivec, m_ivec);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] adr, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; a = adr; idata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; idata = 8'h00;
    endtask

    task automatic ack();
        @(negedge clk);
        inta = 1'b1;
        @(negedge clk);
        inta = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] adr, input logic [7:0] lit);
        cs = 1'b1; rd = 1'b1; a = adr;
        #1;
        chk(name, odata, model_reg(adr));
        chk({name, "_lit"}, odata, lit);
        cs = 1'b0; rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; inta = 1'b0;
        a = 2'd0; idata = 8'h00; ir = 8'h00;
        tick(2);
        reset = 1'b0;
        chk("rst_intr", {7'd0, intr}, 8'h00);
        chk("rst_ivec", ivec, 8'h00);
        rd_chk("rst_imr", 2'd1, 8'hFF);
        rd_chk("rst_irr", 2'd0, 8'h00);
        rd_chk("rst_isr", 2'd2, 8'h00);
        rd_chk("rst_base", 2'd3, 8'h00);
        tick(5);

        // 1: basic request / acknowledge
        wr_reg(2'd1, 8'hFE);
        wr_reg(2'd3, 8'h27);
        rd_chk("base_rd", 2'd3, 8'h20);
        ir = 8'h01;
        tick(3);
        rd_chk("t1_irr", 2'd0, 8'h01);
        chk("t1_intr_lo", {7'd0, intr}, 8'h00);
        ir = 8'h00;
        tick(1);
        chk("t1_intr_hi", {7'd0, intr}, 8'h01);
        ack();
        chk("t1_ivec", ivec, 8'h20);
        rd_chk("t1_isr", 2'd2, 8'h01);
        rd_chk("t1_irr0", 2'd0, 8'h00);
        tick(1);
        chk("t1_intr_drop", {7'd0, intr}, 8'h00);

        // 2: blocked by in-service, released by non-specific EOI
        wr_reg(2'd1, 8'h00);
        ir = 8'h08;
        tick(5);
        rd_chk("t2_irr", 2'd0, 8'h08);
        chk("t2_blocked", {7'd0, intr}, 8'h00);
        wr_reg(2'd0, 8'h20);
        rd_chk("t2_isr", 2'd2, 8'h00);
        tick(1);
        chk("t2_intr", {7'd0, intr}, 8'h01);
        ack();
        chk("t2_ivec", ivec, 8'h23);
        wr_reg(2'd0, 8'h20);
        ir = 8'h00;
        tick(3);

        // 3: simultaneous requests, specific EOI
        ir = 8'h24;
        tick(5);
        rd_chk("t3_irr", 2'd0, 8'h24);
        ack();
        chk("t3_ivec2", ivec, 8'h22);
        rd_chk("t3_isr", 2'd2, 8'h04);
        tick(2);
        chk("t3_blk5", {7'd0, intr}, 8'h00);
        wr_reg(2'd0, 8'h62);
        tick(1);
        chk("t3_intr", {7'd0, intr}, 8'h01);
        ack();
        chk("t3_ivec5", ivec, 8'h25);
        wr_reg(2'd0, 8'h65);
        rd_chk("t3_isr0", 2'd2, 8'h00);
        ir = 8'h00;
        tick(3);

        // 4: masked request fires when unmasked
        wr_reg(2'd1, 8'hFF);
        ir = 8'h02;
        tick(5);
        rd_chk("t4_irr", 2'd0, 8'h02);
        chk("t4_masked", {7'd0, intr}, 8'h00);
        wr_reg(2'd1, 8'hFD);
        tick(1);
        chk("t4_intr", {7'd0, intr}, 8'h01);
        ack();
        chk("t4_ivec", ivec, 8'h21);
        wr_reg(2'd0, 8'h20);
        ir = 8'h00;
        tick(3);

        // 5: spurious acknowledge, level-held line does not re-request
        ack();
        chk("t5_spur", ivec, 8'h27);
        rd_chk("t5_isr", 2'd2, 8'h00);
        wr_reg(2'd1, 8'h00);
        ir = 8'h10;
        tick(5);
        chk("t5_intr", {7'd0, intr}, 8'h01);
        ack();
        chk("t5_ivec", ivec, 8'h24);
        tick(6);
        rd_chk("t5_noreq", 2'd0, 8'h00);
        ir = 8'h00;
        tick(4);
        ir = 8'h10;
        tick(5);
        rd_chk("t5_rereq", 2'd0, 8'h10);

        // 6: asynchronous reset with intr high
        ir = 8'h14;
        tick(5);
        rd_chk("t6_isr", 2'd2, 8'h10);
        chk("t6_intr_hi", {7'd0, intr}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_intr_async", {7'd0, intr}, 8'h00);
        rd_chk("t6_imr", 2'd1, 8'hFF);
        rd_chk("t6_irr", 2'd0, 8'h00);
        rd_chk("t6_isr0", 2'd2, 8'h00);
        tick(2);
        reset = 1'b0;
        tick(8);
        rd_chk("t6_held_noreq", 2'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
